// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/writeback sideband and pipeline-control outputs
// between the RV32I pipeline and hazard_ctrl. The optional performance
// counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
    logic [31:0] inst_d_i;
    logic        RegWEn_d_i;
    logic        br_taken_i;
    logic        RegWEn_wb_i;
    logic [4:0]  rsW_wb_i;

    logic        pc_en_o;
    logic        ifid_en_o;
    logic        ifid_flush_o;
    logic        idex_en_o;
    logic        idex_flush_o;
    logic        stall_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    // Pipeline side: supplies decode/EX/WB status, consumes stall/flush.
    modport master (
        output inst_d_i,
        output RegWEn_d_i,
        output br_taken_i,
        output RegWEn_wb_i,
        output rsW_wb_i,
        input  pc_en_o,
        input  ifid_en_o,
        input  ifid_flush_o,
        input  idex_en_o,
        input  idex_flush_o,
`ifdef HAZARD_PERF_EN
        input  stall_cnt_o,
        input  flush_cnt_o,
`endif
        input  stall_o
    );

    // Hazard unit side.
    modport slave (
        input  inst_d_i,
        input  RegWEn_d_i,
        input  br_taken_i,
        input  RegWEn_wb_i,
        input  rsW_wb_i,
        output pc_en_o,
        output ifid_en_o,
        output ifid_flush_o,
        output idex_en_o,
        output idex_flush_o,
`ifdef HAZARD_PERF_EN
        output stall_cnt_o,
        output flush_cnt_o,
`endif
        output stall_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the non-forwarding RV32I pipeline.
// A per-register scoreboard counts in-flight writes (incremented when a
// writer issues into EX, decremented at writeback). A decode instruction
// whose used sources are pending is held while a bubble enters EX; a taken
// redirect from EX flushes IF/ID and ID/EX and wins over a stall.
// All control outputs are combinational from the scoreboard and inputs.
// Optional feature macro: HAZARD_PERF_EN adds free-running stall and flush
// cycle counters (stall_cnt_o, flush_cnt_o) on the interface.
module hazard_ctrl #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    hazard_ctrl_if.slave  hz
);

    typedef logic [CNTW-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t CNT_ZERO = '0;

    // RV32I major opcodes that matter for source-use decode.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic cnt_t cnt_step(input cnt_t cnt, input logic inc, input logic dec);
        cnt_t res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = (cnt == CNT_MAX)  ? cnt : cnt + 1'b1;
            2'b01:   res = (cnt == CNT_ZERO) ? cnt : cnt - 1'b1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    cnt_t        cnt_q [NREG];

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_d;
    logic        rs1_used;
    logic        rs2_used;
    logic        rs1_pend;
    logic        rs2_pend;
    logic        hazard;
    logic        redirect;
    logic        stall;
    logic        idex_flush;
    logic        issue;
    logic        retire;
    logic        unused_inst_bits;

    assign opcode = hz.inst_d_i[6:0];
    assign rd_d   = hz.inst_d_i[11:7];
    assign rs1    = hz.inst_d_i[19:15];
    assign rs2    = hz.inst_d_i[24:20];

    // funct3/funct7 do not affect which sources are read.
    assign unused_inst_bits = ^{hz.inst_d_i[31:25], hz.inst_d_i[14:12]};

    // Decide which source fields the decode instruction actually reads.
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: rs1_used = 1'b0;
            default:                  rs1_used = 1'b1;
        endcase
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: rs2_used = 1'b1;
            default:                       rs2_used = 1'b0;
        endcase
    end

    // x0 is hardwired, so a source of index 0 never waits on anything.
    assign rs1_pend = rs1_used && (rs1 != 5'd0) && (cnt_q[rs1] != CNT_ZERO);
    assign rs2_pend = rs2_used && (rs2 != 5'd0) && (cnt_q[rs2] != CNT_ZERO);
    assign hazard   = rs1_pend || rs2_pend;

    // A redirect kills the decode instruction, so its hazard is irrelevant.
    assign redirect   = hz.br_taken_i;
    assign stall      = hazard && !redirect;
    assign idex_flush = redirect || stall;

    assign hz.stall_o      = stall;
    assign hz.pc_en_o      = !stall;
    assign hz.ifid_en_o    = !stall;
    assign hz.ifid_flush_o = redirect;
    assign hz.idex_en_o    = 1'b1;
    assign hz.idex_flush_o = idex_flush;

    // Only a writer that really enters EX (not bubbled, not killed) is counted.
    assign issue  = !idex_flush && hz.RegWEn_d_i && (rd_d != 5'd0);
    assign retire = hz.RegWEn_wb_i && (hz.rsW_wb_i != 5'd0);

    // Scoreboard update; entry 0 stays zero because x0 is never tracked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_step(cnt_q[r],
                                     issue  && (rd_d == 5'(r)),
                                     retire && (hz.rsW_wb_i == 5'(r)));
            end
        end
    end

    // More in-flight writers than the counter can hold means the pipeline is
    // deeper than the scoreboard was sized for.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue && !(retire && (hz.rsW_wb_i == rd_d)) && (cnt_q[rd_d] == CNT_MAX)))
        else $error("hazard_ctrl: scoreboard overflow on x%0d", rd_d);

    // A writeback with nothing outstanding means issue and retire disagree.
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(retire && !(issue && (hz.rsW_wb_i == rd_d)) && (cnt_q[hz.rsW_wb_i] == CNT_ZERO)))
        else $error("hazard_ctrl: scoreboard underflow on x%0d", hz.rsW_wb_i);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running cycle counters for stalls and front-end flushes, wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. A counting model of
// in-flight writes predicts every output each cycle; hand-computed stall
// values, reset values and counter totals pin the model.
module tb_hazard_ctrl;

    localparam logic [31:0] I_ADDI_X5   = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] I_ADD_X6_X5 = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] I_ADD_X9_X6 = 32'h006304B3; // add  x9,x6,x6
    localparam logic [31:0] I_ADD_X1_X9 = 32'h000480B3; // add  x1,x9,x0
    localparam logic [31:0] I_ADDI_X7   = 32'h00100393; // addi x7,x0,1
    localparam logic [31:0] I_LUI_X7    = 32'h000013B7; // lui  x7,1
    localparam logic [31:0] I_ADDI_X6X7 = 32'h00038313; // addi x6,x7,0
    localparam logic [31:0] I_ADD_X1_X7 = 32'h007000B3; // add  x1,x0,x7
    localparam logic [31:0] I_SW_X0     = 32'h00000023; // sw   x0,0(x0)
    localparam logic [31:0] I_ADD_X1_X0 = 32'h000000B3; // add  x1,x0,x0
    localparam logic [31:0] I_NOP       = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_ADDI_X10  = 32'h00100513; // addi x10,x0,1
    localparam logic [31:0] I_ADD_X11   = 32'h00A505B3; // add  x11,x10,x10

    logic clk;
    logic rst_n;

    hazard_ctrl_if hz();

    hazard_ctrl #(.NREG(32), .CNTW(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hz     (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Literal expectations posted by the stimulus for the next falling edge.
    bit lit_en    = 1'b0;
    bit lit_stall = 1'b0;
    bit lit_rst   = 1'b0;
    bit lit_perf  = 1'b0;
    int lit_scnt  = 0;
    int lit_fcnt  = 0;

    // ---------------- behavioural model ----------------
    int pend [32];
    int m_stall_cnt;
    int m_flush_cnt;

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic bit m_hazard(input logic [31:0] inst);
        int s1;
        int s2;
        bit h;
        s1 = int'(inst[19:15]);
        s2 = int'(inst[24:20]);
        h  = 1'b0;
        if (reads_rs1(inst[6:0]) && s1 != 0 && pend[s1] > 0) h = 1'b1;
        if (reads_rs2(inst[6:0]) && s2 != 0 && pend[s2] > 0) h = 1'b1;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        int delta [32];
        bit st;
        bit iss;
        bit ret;
        int v;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            st  = m_hazard(hz.inst_d_i) && !hz.br_taken_i;
            iss = !(st || hz.br_taken_i) && hz.RegWEn_d_i && (hz.inst_d_i[11:7] != 5'd0);
            ret = hz.RegWEn_wb_i && (hz.rsW_wb_i != 5'd0);
            for (int i = 0; i < 32; i++) delta[i] = 0;
            if (iss) delta[int'(hz.inst_d_i[11:7])] += 1;
            if (ret) delta[int'(hz.rsW_wb_i)] -= 1;
            for (int i = 1; i < 32; i++) begin
                v = pend[i] + delta[i];
                if (v < 0) v = 0;
                if (v > 3) v = 3;
                pend[i] = v;
            end
            if (st) m_stall_cnt++;
            if (hz.br_taken_i) m_flush_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        bit e_stall;
        bit e_br;
        e_br    = hz.br_taken_i;
        e_stall = m_hazard(hz.inst_d_i) && !e_br;
        check("stall_o",      32'(hz.stall_o),      32'(e_stall));
        check("pc_en_o",      32'(hz.pc_en_o),      32'(!e_stall));
        check("ifid_en_o",    32'(hz.ifid_en_o),    32'(!e_stall));
        check("ifid_flush_o", 32'(hz.ifid_flush_o), 32'(e_br));
        check("idex_en_o",    32'(hz.idex_en_o),    32'd1);
        check("idex_flush_o", 32'(hz.idex_flush_o), 32'(e_br || e_stall));
`ifdef HAZARD_PERF_EN
        check("stall_cnt_o", hz.stall_cnt_o, 32'(m_stall_cnt));
        check("flush_cnt_o", hz.flush_cnt_o, 32'(m_flush_cnt));
`endif
        if (lit_en) begin
            check("lit_stall",      32'(hz.stall_o),      32'(lit_stall));
            check("lit_pc_en",      32'(hz.pc_en_o),      32'(!lit_stall));
            check("lit_ifid_flush", 32'(hz.ifid_flush_o), 32'(e_br));
            check("lit_idex_flush", 32'(hz.idex_flush_o), 32'(lit_stall || e_br));
        end
        if (lit_rst) begin
            check("rst_stall",      32'(hz.stall_o),      32'd0);
            check("rst_pc_en",      32'(hz.pc_en_o),      32'd1);
            check("rst_ifid_en",    32'(hz.ifid_en_o),    32'd1);
            check("rst_ifid_flush", 32'(hz.ifid_flush_o), 32'd0);
            check("rst_idex_en",    32'(hz.idex_en_o),    32'd1);
            check("rst_idex_flush", 32'(hz.idex_flush_o), 32'd0);
`ifdef HAZARD_PERF_EN
            check("rst_stall_cnt", hz.stall_cnt_o, 32'd0);
            check("rst_flush_cnt", hz.flush_cnt_o, 32'd0);
`endif
        end
`ifdef HAZARD_PERF_EN
        if (lit_perf) begin
            check("lit_stall_cnt", hz.stall_cnt_o, 32'(lit_scnt));
            check("lit_flush_cnt", hz.flush_cnt_o, 32'(lit_fcnt));
        end
`endif
    end

    // One decode cycle: drive inputs just after the edge, post the
    // hand-computed stall value, then advance past the next rising edge.
    task automatic cyc(input logic [31:0] inst, input bit wd, input bit br,
                       input bit ww, input logic [4:0] rsw, input bit exp_stall);
        hz.inst_d_i    = inst;
        hz.RegWEn_d_i  = wd;
        hz.br_taken_i  = br;
        hz.RegWEn_wb_i = ww;
        hz.rsW_wb_i    = rsw;
        lit_en         = 1'b1;
        lit_stall      = exp_stall;
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        hz.inst_d_i    = I_NOP;
        hz.RegWEn_d_i  = 1'b0;
        hz.br_taken_i  = 1'b0;
        hz.RegWEn_wb_i = 1'b0;
        hz.rsW_wb_i    = 5'd0;
        lit_rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        lit_rst = 1'b0;

        // RAW: producer, then dependent stalls exactly 3 cycles.
        cyc(I_ADDI_X5,   1, 0, 0, 5'd0, 0);
        cyc(I_ADD_X6_X5, 1, 0, 0, 5'd0, 1);
        cyc(I_ADD_X6_X5, 1, 0, 0, 5'd0, 1);
        cyc(I_ADD_X6_X5, 1, 0, 1, 5'd5, 1);
        cyc(I_ADD_X6_X5, 1, 0, 0, 5'd0, 0);
        // Redirect over a hazard (x6 pending) with a counted rd=9 in decode.
        cyc(I_ADD_X9_X6, 1, 1, 0, 5'd0, 0);
        // x9 must not be pending; x6 retires.
        lit_perf = 1'b1;
        lit_scnt = 3;
        lit_fcnt = 1;
        cyc(I_ADD_X1_X9, 0, 0, 1, 5'd6, 0);
        lit_perf = 1'b0;

        // No false hazards.
        cyc(I_ADDI_X7,   1, 0, 0, 5'd0, 0);
        cyc(I_LUI_X7,    0, 0, 0, 5'd0, 0);
        cyc(I_ADDI_X6X7, 0, 0, 0, 5'd0, 1);
        cyc(I_ADD_X1_X7, 0, 0, 0, 5'd0, 1);
        cyc(I_SW_X0,     0, 0, 0, 5'd0, 0);
        cyc(I_ADD_X1_X0, 0, 0, 0, 5'd0, 0);
        cyc(I_NOP,       1, 0, 0, 5'd0, 0);
        cyc(I_ADDI_X6X7, 0, 0, 1, 5'd7, 1);
        cyc(I_ADDI_X6X7, 0, 0, 0, 5'd0, 0);

        // Same-register issue/retire and full depth of three writers.
        cyc(I_ADDI_X10, 1, 0, 0, 5'd0,  0);
        cyc(I_ADDI_X10, 1, 0, 1, 5'd10, 0);
        cyc(I_ADD_X11,  0, 0, 0, 5'd0,  1);
        cyc(I_ADDI_X10, 1, 0, 0, 5'd0,  0);
        cyc(I_ADDI_X10, 1, 0, 0, 5'd0,  0);
        cyc(I_ADD_X11,  0, 0, 1, 5'd10, 1);
        cyc(I_ADD_X11,  0, 0, 1, 5'd10, 1);
        cyc(I_ADD_X11,  0, 0, 1, 5'd10, 1);
        cyc(I_ADD_X11,  0, 0, 0, 5'd0,  0);

        // Reset in the middle of a stall with x5 counted twice.
        cyc(I_ADDI_X5,   1, 0, 0, 5'd0, 0);
        cyc(I_ADDI_X5,   1, 0, 0, 5'd0, 0);
        cyc(I_ADD_X6_X5, 1, 0, 0, 5'd0, 1);
        #1;
        rst_n   = 1'b0;
        lit_rst = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        lit_rst = 1'b0;
        cyc(I_ADD_X6_X5, 0, 0, 0, 5'd0, 0);
        cyc(I_NOP,       0, 0, 0, 5'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline-control block that drives the stall (enable) and flush (reset) inputs of the PC, IF/ID and ID/EX registers in the non-forwarding RV32I pipeline.
- Keeps a per-register scoreboard of in-flight writes.
  - Issue into EX increments it; the writeback port decrements it.
  - An instruction in decode whose source registers are pending is held, and a bubble goes into EX.
- A taken branch or jump resolved in EX flushes both younger stages.

## Interface

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNTW, 2, per-register pending-count width; covers up to 3 in-flight writers (EX, MEM, WB).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- inst_d_i  in  32  instruction in decode (IF/ID output).
- RegWEn_d_i  in  1  decode-stage register-write enable from ctrl_unit.
- br_taken_i  in  1  EX-stage redirect (taken branch, JAL, JALR).
- RegWEn_wb_i  in  1  writeback register-write enable (same net as the regfile write enable).
- rsW_wb_i  in  5  writeback destination register.
- pc_en_o  out  1  PC register enable.
- ifid_en_o  out  1  IF/ID enable.
- ifid_flush_o  out  1  IF/ID synchronous clear.
- idex_en_o  out  1  ID/EX enable (drives enable_i of the ID stage).
- idex_flush_o  out  1  ID/EX synchronous clear (drives reset_i of the ID stage).
- stall_o  out  1  data-hazard stall active this cycle.

## Operation

- Source-use decode from inst_d_i[6:0]:
  - rs1 is used for all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only for R-type, STORE and BRANCH.
  - A source with index 0 is never a hazard.
- hazard = (rs1 used and cnt[rs1] != 0) or (rs2 used and cnt[rs2] != 0).
- Output equations:
  - redirect = br_taken_i.
  - stall_o = hazard and not redirect.
  - pc_en_o = not stall_o.
  - ifid_en_o = not stall_o.
  - ifid_flush_o = redirect.
  - idex_en_o = 1.
  - idex_flush_o = redirect or stall_o.
- Issue condition: issue = idex_en_o and not idex_flush_o and RegWEn_d_i and (inst_d_i[11:7] != 0).
- Retire condition: retire = RegWEn_wb_i and (rsW_wb_i != 0).
- Per register r, at each posedge:
  - cnt[r] += 1 if issue targets r.
  - cnt[r] -= 1 if retire targets r.
  - Both at once on the same r: no change.
- Required invariants:
  - No increment when cnt[r] = 2^CNTW-1.
  - No decrement when cnt[r] = 0.
  - Both are simulation assertions; the RTL saturates in both directions.
- Redirect beats stall in the same cycle. The killed decode instruction is never counted.
- Redirect does not touch the scoreboard. The branch/jump itself has already issued and retires normally.

## Timing

- All outputs are combinational from the current scoreboard state and the inputs; there are no registered outputs.
- Scoreboard updates on posedge clk_i.
- Asynchronous reset (rst_ni low):
  - All cnt cleared immediately.
  - Outputs then follow their equations; with br_taken_i=0 they are pc_en_o=1, ifid_en_o=1, ifid_flush_o=0, idex_en_o=1, idex_flush_o=0, stall_o=0.
- Reset mid-operation discards all pending state. The pipeline registers reset on the same rst_ni, so they stay consistent.
- Dependent-pair latency, with no forwarding and writeback visible to decode only after the WB edge:
  - A dependent instruction directly behind its producer stalls 3 cycles.
  - It proceeds in the cycle after the producer's WB edge clears cnt.
- Retire and hazard check in the same cycle: decode still sees the old count and stalls. It releases on the next cycle, so regfile write-through is not required.

## Configuration

- HAZARD_PERF_EN defined:
  - Adds outputs stall_cnt_o (32) and flush_cnt_o (32).
  - stall_cnt_o increments every cycle stall_o=1.
  - flush_cnt_o increments every cycle ifid_flush_o=1.
  - Both wrap modulo 2^32 and clear on rst_ni low.
- HAZARD_PERF_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan

- **Reset:** assert rst_ni=0 mid-stall with cnt[x5]=2 -> all outputs at their reset values immediately. After release, decode `add x6,x5,x5` is not stalled.
- **RAW stall:** `addi x5,x0,1` then `add x6,x5,x5` -> stall_o=1 for exactly 3 cycles.
  - During the stall: idex_flush_o=1 and pc_en_o=0.
  - Released in the cycle after rsW_wb_i=5 retires.
- **No false hazard:**
  - `lui x7,1` behind a pending x7 writer -> stall_o=0.
  - `sw x0,0(x0)` and any instruction sourcing x0 -> stall_o=0.
  - A writer with rd=x0 leaves cnt unchanged.
- **Redirect vs stall:** br_taken_i=1 while decode has a hazard.
  - ifid_flush_o=1, idex_flush_o=1, stall_o=0, pc_en_o=1.
  - Scoreboard unchanged; a counted decode RegWEn_d_i=1 rd=9 leaves cnt[9]=0.
- **Same-register inc/dec:**
  - Issue rd=10 in the same cycle as retire rsW_wb_i=10 with cnt[10]=1 -> cnt[10] stays 1.
  - Three back-to-back writers to x10 -> cnt[10]=3; then three retires -> 0.
- **HAZARD_PERF_EN:** the RAW scenario plus one redirect -> stall_cnt_o=3, flush_cnt_o=1.
